// File: rtl/flag_update_unit.sv
`default_nettype none
//============================================================================
// Module   : flag_update_unit
// Purpose  : Architectural NZCV register with a saved-flags LIFO, sticky
//            stack-error status and a saturating flag-write counter.
//            Optional macro FLAG_FWD_EN: FlagsNext forwards next-state.
// Revision : 1.0  initial release
//============================================================================
module flag_update_unit #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             Valid,
  input  logic             CondEx,
  input  logic [1:0]       FlagW,
  input  logic [3:0]       ALUFlags,
  input  logic             Save,
  input  logic             Restore,
  input  logic             ErrClr,
  output logic [3:0]       Flags,
  output logic [3:0]       FlagsNext,
  output logic             Full,
  output logic             Empty,
  output logic             Err,
  output logic [CNT_W-1:0] WrCount
);

  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [SP_W-1:0] C_DEPTH = SP_W'(DEPTH);
  localparam logic [SP_W-1:0] C_ONE   = SP_W'(1);

  logic [3:0]       r_flags;
  logic [SP_W-1:0]  r_sp;
  logic             r_full;
  logic             r_empty;
  logic             r_err;
  logic [CNT_W-1:0] r_wrCount;
  logic [3:0]       r_stack [DEPTH];

  logic             w_we;
  logic [3:0]       w_merged;
  logic             w_saveOnly;
  logic             w_restoreOnly;
  logic             w_push;
  logic             w_pop;
  logic             w_errSet;
  logic             w_countUp;
  logic [SP_W-1:0]  w_spDec;
  logic [SP_W-1:0]  w_spNext;
  logic [IDX_W-1:0] w_pushIdx;
  logic [IDX_W-1:0] w_popIdx;
  logic [3:0]       w_flagsNext;

  assign w_we          = Valid & CondEx & (FlagW != 2'b00);
  assign w_saveOnly    = Save & ~Restore;
  assign w_restoreOnly = Restore & ~Save;
  assign w_push        = w_saveOnly & ~r_full;
  assign w_pop         = w_restoreOnly & ~r_empty;
  // A simultaneous Save/Restore is a conflict: neither stack op happens.
  assign w_errSet      = (Save & Restore) | (w_saveOnly & r_full) | (w_restoreOnly & r_empty);
  assign w_countUp     = w_we & ~w_pop;

  assign w_spDec   = r_sp - C_ONE;
  assign w_pushIdx = r_sp[IDX_W-1:0];
  assign w_popIdx  = w_spDec[IDX_W-1:0];

  always_comb begin
    w_merged = r_flags;
    if (w_we) begin
      if (FlagW[1]) w_merged[3:2] = ALUFlags[3:2];
      if (FlagW[0]) w_merged[1:0] = ALUFlags[1:0];
    end
  end

  always_comb begin
    w_flagsNext = w_merged;
    w_spNext    = r_sp;
    if (w_pop) begin
      w_flagsNext = r_stack[w_popIdx];
      w_spNext    = w_spDec;
    end else if (w_push) begin
      w_spNext    = r_sp + C_ONE;
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_flags   <= 4'b0000;
      r_sp      <= '0;
      r_full    <= 1'b0;
      r_empty   <= 1'b1;
      r_err     <= 1'b0;
      r_wrCount <= '0;
    end else begin
      r_flags <= w_flagsNext;
      r_sp    <= w_spNext;
      r_full  <= (w_spNext == C_DEPTH);
      r_empty <= (w_spNext == '0);
      if (w_errSet) begin
        r_err <= 1'b1;
      end else if (ErrClr) begin
        r_err <= 1'b0;
      end
      if (w_countUp && (r_wrCount != '1)) begin
        r_wrCount <= r_wrCount + CNT_W'(1);
      end
    end
  end

  // Stack storage carries no reset; only entries below sp are ever read.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_stack[w_pushIdx] <= r_flags;
    end
  end

`ifdef FLAG_FWD_EN
  assign FlagsNext = w_flagsNext;
`else
  assign FlagsNext = r_flags;
`endif

  assign Flags   = r_flags;
  assign Full    = r_full;
  assign Empty   = r_empty;
  assign Err     = r_err;
  assign WrCount = r_wrCount;

endmodule
`default_nettype wire

// File: tb/tb_flag_update_unit.sv
`default_nettype none
//============================================================================
// Module   : tb_flag_update_unit
// Purpose  : Directed self-checking bench with a queue-based flags model.
// Revision : 1.0  initial release
//============================================================================
module tb_flag_update_unit;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic       CLK = 1'b0;
  logic       RESETn = 1'b0;
  logic       Valid = 1'b0;
  logic       CondEx = 1'b0;
  logic [1:0] FlagW = 2'b00;
  logic [3:0] ALUFlags = 4'b0000;
  logic       Save = 1'b0;
  logic       Restore = 1'b0;
  logic       ErrClr = 1'b0;

  logic [3:0]       Flags, FlagsNext;
  logic             Full, Empty, Err;
  logic [CNT_W-1:0] WrCount;
  logic [3:0]       flags3, flagsNext3;
  logic             full3, empty3, err3;
  logic [2:0]       wrCount3;

  flag_update_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_dut (
    .CLK(CLK), .RESETn(RESETn), .Valid(Valid), .CondEx(CondEx), .FlagW(FlagW),
    .ALUFlags(ALUFlags), .Save(Save), .Restore(Restore), .ErrClr(ErrClr),
    .Flags(Flags), .FlagsNext(FlagsNext), .Full(Full), .Empty(Empty),
    .Err(Err), .WrCount(WrCount)
  );

  flag_update_unit #(.DEPTH(DEPTH), .CNT_W(3)) u_dut3 (
    .CLK(CLK), .RESETn(RESETn), .Valid(Valid), .CondEx(CondEx), .FlagW(FlagW),
    .ALUFlags(ALUFlags), .Save(Save), .Restore(Restore), .ErrClr(ErrClr),
    .Flags(flags3), .FlagsNext(flagsNext3), .Full(full3), .Empty(empty3),
    .Err(err3), .WrCount(wrCount3)
  );

  always #5 CLK = ~CLK;

  int nCmp = 0;
  int nBad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: flags word, saved-flags queue, sticky error, counters.
  logic [3:0] mFlags;
  logic [3:0] mStack [$];
  logic       mErr;
  int         mCnt;
  int         mCnt3;

  function automatic logic [3:0] modelNext();
    logic [3:0] nf;
    nf = mFlags;
    if (Valid && CondEx) begin
      if (FlagW[1]) nf[3:2] = ALUFlags[3:2];
      if (FlagW[0]) nf[1:0] = ALUFlags[1:0];
    end
    if (Restore && !Save && mStack.size() > 0) nf = mStack[$];
    return nf;
  endfunction

  always @(posedge CLK or negedge RESETn) begin : model
    logic [3:0] nf;
    bit popped;
    bit errNow;
    if (!RESETn) begin
      mFlags = 4'b0000;
      mStack.delete();
      mErr   = 1'b0;
      mCnt   = 0;
      mCnt3  = 0;
    end else begin
      nf     = modelNext();
      popped = Restore && !Save && mStack.size() > 0;
      errNow = 1'b0;
      if (Save && Restore) errNow = 1'b1;
      else if (Save) begin
        if (mStack.size() == DEPTH) errNow = 1'b1;
        else mStack.push_back(mFlags);
      end else if (Restore) begin
        if (mStack.size() == 0) errNow = 1'b1;
        else void'(mStack.pop_back());
      end
      if (Valid && CondEx && FlagW != 2'b00 && !popped) begin
        if (mCnt < 255) mCnt++;
        if (mCnt3 < 7) mCnt3++;
      end
      mErr   = errNow ? 1'b1 : (ErrClr ? 1'b0 : mErr);
      mFlags = nf;
    end
  end

  always @(negedge CLK) begin
    check("Flags", Flags, mFlags);
    check("Full", Full, mStack.size() == DEPTH);
    check("Empty", Empty, mStack.size() == 0);
    check("Err", Err, mErr);
    check("WrCount", WrCount, mCnt);
    check("WrCount3", wrCount3, mCnt3);
`ifdef FLAG_FWD_EN
    check("FlagsNext", FlagsNext, modelNext());
`else
    check("FlagsNext", FlagsNext, mFlags);
`endif
  end

  task automatic cyc(input logic v, input logic c, input logic [1:0] fw, input logic [3:0] alu,
                     input logic s, input logic r, input logic ec);
    Valid = v; CondEx = c; FlagW = fw; ALUFlags = alu;
    Save = s; Restore = r; ErrClr = ec;
    @(posedge CLK);
    #2;
    Valid = 1'b0; CondEx = 1'b0; FlagW = 2'b00; ALUFlags = 4'b0000;
    Save = 1'b0; Restore = 1'b0; ErrClr = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #2 RESETn = 1'b1;
    check("rst_flags", Flags, 4'b0000);
    check("rst_empty", Empty, 1'b1);
    check("rst_full", Full, 1'b0);
    check("rst_err", Err, 1'b0);
    check("rst_cnt", WrCount, 0);

    // Forwarding: inputs held, no edge yet.
    Valid = 1'b1; CondEx = 1'b1; FlagW = 2'b10; ALUFlags = 4'b0100;
    #1;
`ifdef FLAG_FWD_EN
    check("fwd_next", FlagsNext, 4'b0100);
`else
    check("fwd_next", FlagsNext, 4'b0000);
`endif
    @(posedge CLK);
    #2;
    Valid = 1'b0; CondEx = 1'b0; FlagW = 2'b00; ALUFlags = 4'b0000;
    check("fwd_flags", Flags, 4'b0100);

    // Partial merges and condition-failed write.
    cyc(1, 1, 2'b10, 4'b1111, 0, 0, 0); check("nz_merge", Flags, 4'b1100);
    cyc(1, 1, 2'b01, 4'b0001, 0, 0, 0); check("cv_merge", Flags, 4'b1101);
    cyc(1, 0, 2'b11, 4'b0000, 0, 0, 0); check("cond_fail", Flags, 4'b1101);
    check("cnt_3", WrCount, 3);

    // Save then Restore back-to-back, both with concurrent writes.
    cyc(1, 1, 2'b11, 4'b0110, 0, 0, 0); check("set_0110", Flags, 4'b0110);
    cyc(1, 1, 2'b11, 4'b1001, 1, 0, 0); check("save_wr", Flags, 4'b1001);
    check("save_nempty", Empty, 1'b0);
    cyc(1, 1, 2'b11, 4'b1111, 0, 1, 0); check("restore_val", Flags, 4'b0110);
    check("restore_cnt", WrCount, 5);
    check("restore_empty", Empty, 1'b1);

    // Fill, overflow, LIFO drain, underflow, clear.
    cyc(1, 1, 2'b11, 4'b0001, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, 2'b11, 4'(i + 2), 1, 0, 0);
      if (i == 3) begin
        check("full_4", Full, 1'b1);
        check("noerr_4", Err, 1'b0);
      end
    end
    check("ovf_err", Err, 1'b1);
    check("ovf_flags", Flags, 4'b0110);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 2'b00, 4'b0000, 0, 1, 0);
      check("lifo", Flags, 4'(4 - i));
    end
    check("drain_empty", Empty, 1'b1);
    cyc(0, 0, 2'b00, 4'b0000, 0, 1, 0);
    check("unf_flags", Flags, 4'b0001);
    check("unf_err", Err, 1'b1);
    cyc(0, 0, 2'b00, 4'b0000, 0, 0, 1); check("errclr", Err, 1'b0);

    // Save/Restore conflict with sp=1, then set-wins over clear.
    cyc(0, 0, 2'b00, 4'b0000, 1, 0, 0);
    cyc(1, 1, 2'b11, 4'b1010, 1, 1, 0);
    check("conf_err", Err, 1'b1);
    check("conf_nempty", Empty, 1'b0);
    check("conf_flags", Flags, 4'b1010);
    cyc(0, 0, 2'b00, 4'b0000, 0, 1, 0);
    check("conf_pop", Flags, 4'b0001);
    check("conf_sp1", Empty, 1'b1);
    cyc(0, 0, 2'b00, 4'b0000, 0, 1, 1); check("set_wins", Err, 1'b1);
    cyc(0, 0, 2'b00, 4'b0000, 0, 0, 1); check("errclr2", Err, 0);

    // Asynchronous reset away from any clock edge.
    cyc(1, 1, 2'b11, 4'b1011, 1, 0, 0);
    cyc(0, 0, 2'b00, 4'b0000, 1, 0, 0);
    cyc(0, 0, 2'b00, 4'b0000, 1, 1, 0);
    #1 RESETn = 1'b0;
    #1;
    check("arst_flags", Flags, 4'b0000);
    check("arst_empty", Empty, 1'b1);
    check("arst_err", Err, 1'b0);
    check("arst_cnt", WrCount, 0);
    @(posedge CLK);
    #2 RESETn = 1'b1;

    // Counter saturation in both widths.
    for (int i = 0; i < 9; i++) begin
      cyc(1, 1, 2'b01, 4'(i), 0, 0, 0);
      cyc(1, 0, 2'b01, 4'(i), 0, 0, 0);
    end
    check("cnt9", WrCount, 9);
    check("cnt3_sat", wrCount3, 3'd7);
    for (int i = 0; i < 250; i++) cyc(1, 1, 2'b10, 4'(i), 0, 0, 0);
    check("cnt8_sat", WrCount, 255);
    cyc(1, 1, 2'b11, 4'b1111, 0, 0, 0);
    check("cnt8_hold", WrCount, 255);

    @(negedge CLK);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
`default_nettype wire
